// File: rtl/toggle_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : toggle_sequencer
// Description : Command-driven pacing controller for an internal bank of
//               WIDTH T flip-flops (masked, counted, gapped toggling).
// Revision    : 1.0 - initial release
// ============================================================================
module toggle_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8,
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_mask,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [GAP_W-1:0] cmd_gap,
    input  logic             abort,
    output logic [WIDTH-1:0] t,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] toggles_left
);

    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);
    localparam logic [GAP_W-1:0] c_GAP_ONE = GAP_W'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_TOGGLE = 2'd1,
        S_GAP    = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_mask;
    logic [GAP_W-1:0] r_gap;
    logic [GAP_W-1:0] r_gap_cnt;
    logic [CNT_W-1:0] r_left;
    logic [WIDTH-1:0] r_q;
    logic             r_done;
    logic             r_busy;
    logic [WIDTH-1:0] w_t;

    // abort gates the bank in the same cycle so the pending toggle never lands
    assign w_t       = (r_state == S_TOGGLE && !abort) ? r_mask : '0;
    assign cmd_ready = (r_state == S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_mask    <= '0;
            r_gap     <= '0;
            r_gap_cnt <= '0;
            r_left    <= '0;
            r_q       <= '0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_q    <= r_q ^ w_t;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_mask <= cmd_mask;
                        r_gap  <= cmd_gap;
                        r_busy <= 1'b1;
                        if (cmd_count == '0 || cmd_mask == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_left  <= '0;
                        end else begin
                            r_state <= S_TOGGLE;
                            r_left  <= cmd_count;
                        end
                    end
                end
                S_TOGGLE: begin
                    if (abort) begin
                        r_state   <= S_DONE;
                        r_done    <= 1'b1;
                        r_left    <= '0;
                        r_gap_cnt <= '0;
                    end else begin
                        r_left <= r_left - c_CNT_ONE;
                        if (r_left == c_CNT_ONE) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else if (r_gap != '0) begin
                            r_state   <= S_GAP;
                            r_gap_cnt <= r_gap;
                        end
                    end
                end
                S_GAP: begin
                    if (abort) begin
                        r_state   <= S_DONE;
                        r_done    <= 1'b1;
                        r_left    <= '0;
                        r_gap_cnt <= '0;
                    end else if (r_gap_cnt <= c_GAP_ONE) begin
                        r_state   <= S_TOGGLE;
                        r_gap_cnt <= '0;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - c_GAP_ONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign t            = w_t;
    assign q            = r_q;
    assign q_bar        = ~r_q;
    assign busy         = r_busy;
    assign done         = r_done;
    assign toggles_left = r_left;

endmodule
`default_nettype wire

// File: tb/tb_toggle_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_toggle_sequencer
// Description : Directed vector table, reset sequences and randomized
//               traffic against a schedule-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_toggle_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [3:0] cmd_mask = '0;
    logic [7:0] cmd_count = '0;
    logic [3:0] cmd_gap = '0;
    logic       abort = 1'b0;
    logic [3:0] t, q, q_bar;
    logic       busy, done;
    logic [7:0] toggles_left;

    int n_vec = 0;
    int n_err = 0;

    toggle_sequencer #(.WIDTH(4), .CNT_W(8), .GAP_W(4)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_mask(cmd_mask), .cmd_count(cmd_count), .cmd_gap(cmd_gap),
        .abort(abort),
        .t(t), .q(q), .q_bar(q_bar),
        .busy(busy), .done(done), .toggles_left(toggles_left)
    );

    always #5 clk = ~clk;

    // Reference model: cycle index since acceptance, toggle schedule by arithmetic
    int         m_mode;   // 0 idle, 1 running, 2 done cycle
    int         m_c, m_n, m_g;
    logic [3:0] m_mask, m_q;

    function automatic logic [22:0] model_out();
        logic [3:0] et;
        logic [7:0] etl;
        int         completed;
        et  = 4'h0;
        etl = 8'd0;
        case (m_mode)
            0: return {4'h0, m_q, ~m_q, 1'b0, 1'b0, 1'b1, 8'd0};
            2: return {4'h0, m_q, ~m_q, 1'b1, 1'b1, 1'b0, 8'd0};
            default: begin
                if (((m_c - 1) % (m_g + 1)) == 0 && !abort) et = m_mask;
                completed = (m_c == 1) ? 0 : (m_c - 2) / (m_g + 1) + 1;
                etl = 8'(m_n - completed);
                return {et, m_q, ~m_q, 1'b1, 1'b0, 1'b0, etl};
            end
        endcase
    endfunction

    task automatic model_step();
        int k;
        case (m_mode)
            0: if (cmd_valid) begin
                m_mask = cmd_mask; m_n = int'(cmd_count); m_g = int'(cmd_gap);
                if (m_n == 0 || m_mask == 4'h0) m_mode = 2;
                else begin m_mode = 1; m_c = 1; end
            end
            2: m_mode = 0;
            default: begin
                k = m_n + (m_n - 1) * m_g;
                if (((m_c - 1) % (m_g + 1)) == 0 && !abort) m_q = m_q ^ m_mask;
                if (abort || m_c == k) m_mode = 2;
                else m_c = m_c + 1;
            end
        endcase
    endtask

    task automatic model_reset();
        m_mode = 0; m_c = 0; m_n = 0; m_g = 0; m_mask = 4'h0; m_q = 4'h0;
    endtask

    function automatic logic [22:0] dut_out();
        return {t, q, q_bar, busy, done, cmd_ready, toggles_left};
    endfunction

    task automatic check(input string name, input logic [22:0] act, input logic [22:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got t/q/qb/busy/done/rdy/left=%h required %h", name, act, exp);
        end
    endtask

    // One clock cycle; inputs already driven, entered just after a rising edge
    task automatic cycle(input string name);
        #4;
        check(name, dut_out(), model_out());
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] m, input logic [7:0] n,
                         input logic [3:0] g, input logic a);
        cmd_valid = v; cmd_mask = m; cmd_count = n; cmd_gap = g; abort = a;
    endtask

    typedef struct {
        logic       v, a;
        logic [3:0] m;
        logic [7:0] n;
        logic [3:0] g;
        logic [3:0] e_t, e_q;
        logic       e_done, e_ready, e_busy;
        logic [7:0] e_tl;
    } vec_t;

    vec_t tbl[22];

    initial begin
        // single toggle
        tbl[0]  = '{1,0,4'h5,8'd1,4'd0, 4'h0,4'h0,0,1,0,8'd0};
        tbl[1]  = '{0,0,4'h0,8'd0,4'd0, 4'h5,4'h0,0,0,1,8'd1};
        tbl[2]  = '{0,0,4'h0,8'd0,4'd0, 4'h0,4'h5,1,0,1,8'd0};
        tbl[3]  = '{0,0,4'h0,8'd0,4'd0, 4'h0,4'h5,0,1,0,8'd0};
        // degenerate: N=0, then mask=0
        tbl[4]  = '{1,0,4'hF,8'd0,4'd0, 4'h0,4'h5,0,1,0,8'd0};
        tbl[5]  = '{0,0,4'h0,8'd0,4'd0, 4'h0,4'h5,1,0,1,8'd0};
        tbl[6]  = '{1,0,4'h0,8'd5,4'd0, 4'h0,4'h5,0,1,0,8'd0};
        tbl[7]  = '{0,0,4'h0,8'd0,4'd0, 4'h0,4'h5,1,0,1,8'd0};
        // paced: N=3, G=2
        tbl[8]  = '{1,0,4'hF,8'd3,4'd2, 4'h0,4'h5,0,1,0,8'd0};
        tbl[9]  = '{0,0,4'h0,8'd0,4'd0, 4'hF,4'h5,0,0,1,8'd3};
        tbl[10] = '{0,0,4'h0,8'd0,4'd0, 4'h0,4'hA,0,0,1,8'd2};
        tbl[11] = '{0,0,4'h0,8'd0,4'd0, 4'h0,4'hA,0,0,1,8'd2};
        tbl[12] = '{0,0,4'h0,8'd0,4'd0, 4'hF,4'hA,0,0,1,8'd2};
        tbl[13] = '{0,0,4'h0,8'd0,4'd0, 4'h0,4'h5,0,0,1,8'd1};
        tbl[14] = '{0,0,4'h0,8'd0,4'd0, 4'h0,4'h5,0,0,1,8'd1};
        tbl[15] = '{0,0,4'h0,8'd0,4'd0, 4'hF,4'h5,0,0,1,8'd1};
        tbl[16] = '{0,0,4'h0,8'd0,4'd0, 4'h0,4'hA,1,0,1,8'd0};
        // abort in first gap cycle: N=4, G=3
        tbl[17] = '{1,0,4'h3,8'd4,4'd3, 4'h0,4'hA,0,1,0,8'd0};
        tbl[18] = '{0,0,4'h0,8'd0,4'd0, 4'h3,4'hA,0,0,1,8'd4};
        tbl[19] = '{0,1,4'h0,8'd0,4'd0, 4'h0,4'h9,0,0,1,8'd3};
        tbl[20] = '{0,0,4'h0,8'd0,4'd0, 4'h0,4'h9,1,0,1,8'd0};
        tbl[21] = '{0,0,4'h0,8'd0,4'd0, 4'h0,4'h9,0,1,0,8'd0};
    end

    initial begin
        model_reset();
        #2;
        check("reset_held", dut_out(), {4'h0, 4'h0, 4'hF, 1'b0, 1'b0, 1'b1, 8'd0});
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 22; i++) begin
            drive(tbl[i].v, tbl[i].m, tbl[i].n, tbl[i].g, tbl[i].a);
            #4;
            check($sformatf("table[%0d]", i), dut_out(),
                  {tbl[i].e_t, tbl[i].e_q, ~tbl[i].e_q, tbl[i].e_busy, tbl[i].e_done,
                   tbl[i].e_ready, tbl[i].e_tl});
            check($sformatf("table_model[%0d]", i), dut_out(), model_out());
            @(posedge clk);
            model_step();
            #1;
        end

        // backpressure: next command held valid while busy
        drive(1, 4'h6, 8'd2, 4'd1, 0);
        for (int i = 0; i < 8; i++) cycle("backpressure");
        drive(0, 4'h0, 8'd0, 4'd0, 0);
        for (int i = 0; i < 6; i++) cycle("backpressure_drain");

        // abort during TOGGLE, with a new command offered in the following IDLE cycle
        drive(1, 4'hC, 8'd3, 4'd0, 0);
        cycle("abort_toggle_accept");
        drive(0, 4'h0, 8'd0, 4'd0, 1);
        cycle("abort_toggle");
        drive(0, 4'h0, 8'd0, 4'd0, 1);
        cycle("abort_in_done");
        drive(1, 4'h1, 8'd1, 4'd0, 1);
        cycle("abort_in_idle_accept");
        drive(0, 4'h0, 8'd0, 4'd0, 0);
        for (int i = 0; i < 3; i++) cycle("abort_in_idle_run");

        // reset asserted mid-cycle during TOGGLE
        drive(1, 4'hF, 8'd4, 4'd0, 0);
        cycle("rst_mid_accept");
        drive(0, 4'h0, 8'd0, 4'd0, 0);
        cycle("rst_mid_toggle");
        #2 rst = 1'b1;
        #1;
        check("rst_async", dut_out(), {4'h0, 4'h0, 4'hF, 1'b0, 1'b0, 1'b1, 8'd0});
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        cycle("rst_release_ready");

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            cmd_valid = ($urandom_range(0, 2) != 0);
            cmd_mask  = 4'($urandom_range(0, 15));
            cmd_count = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 4));
            cmd_gap   = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
            abort     = ($urandom_range(0, 19) == 0);
            cycle("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/toggle_sequencer.md
# toggle_sequencer

Command-driven controller for a bank of WIDTH T flip-flops. It accepts toggle commands over a valid/ready handshake and drives the bank's T inputs to toggle a masked subset of bits a programmed number of times, with a programmable idle gap between toggles. The flip-flop bank is instantiated inside this block, so q/q_bar are observable at its boundary. It sits between a host/control FSM and any logic that needs deterministic, paced T-flip-flop toggling, such as clock-enable patterns or test toggles.

## Interface
- WIDTH, 4, number of T flip-flops in the bank
- CNT_W, 8, width of toggle-count field
- GAP_W, 4, width of inter-toggle gap field
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  block can accept a command (IDLE only)
- cmd_mask  input  WIDTH  bits to toggle
- cmd_count  input  CNT_W  number of toggles N
- cmd_gap  input  GAP_W  idle cycles G between toggles
- abort  input  1  synchronous cancel of the active command
- t  output  WIDTH  T inputs presented to the bank
- q  output  WIDTH  flip-flop bank state
- q_bar  output  WIDTH  always ~q
- busy  output  1  state != IDLE
- done  output  1  one-cycle pulse at command completion or abort
- toggles_left  output  CNT_W  remaining toggles of the active command

## Operation
- **Bank:**
  - q <= q ^ t on every rising clk edge.
  - t = latched mask in TOGGLE state while abort=0; otherwise all zeros.
- **States:** IDLE, TOGGLE, GAP, DONE.
- **IDLE:**
  - cmd_ready=1.
  - A command is accepted on the edge where cmd_valid && cmd_ready; mask, count and gap are latched at that edge.
  - If cmd_count==0 or cmd_mask==0: next state DONE, with no toggles.
  - Otherwise: next state TOGGLE, toggles_left=cmd_count.
- **TOGGLE:**
  - Lasts one cycle; toggles_left decrements at the edge ending it.
  - If the decremented value is 0 -> DONE.
  - Else if G==0 -> stay in TOGGLE.
  - Else -> GAP with the gap counter loaded to G.
- **GAP:**
  - Lasts exactly G cycles; t=0.
  - Returns to TOGGLE after the counter expires.
- **DONE:**
  - done=1 for exactly one cycle, then IDLE.
  - cmd_ready=0 during DONE.
- **abort:**
  - In TOGGLE or GAP: forces t=0 combinationally in the same cycle. Next state DONE; toggles_left cleared to 0. q retains its current value.
  - In IDLE or DONE: ignored. In IDLE, a command with cmd_valid in the same cycle is still accepted.
- **Back-to-back commands:** q is not cleared between commands. Toggling continues from the current q.
- **Reset (async, any time including mid-command):**
  - State IDLE; q=0, q_bar=all ones.
  - t=0, done=0, busy=0, toggles_left=0, internal gap counter=0.
  - cmd_ready=1 after reset deasserts.

## Timing
- Label the accept edge E0.
  - TOGGLE occupies the cycle after E0.
  - First q change at edge E1.
- With N≥1 and G, toggles occur at edges E1, E(1+(G+1)), … E(1+(N-1)(G+1)).
  - The last toggle is at edge Ek, where k = N + (N-1)·G.
  - done is high during cycle k+1; IDLE and cmd_ready=1 follow from edge E(k+1).
- Degenerate command (N=0 or mask=0): done during cycle 1; IDLE from E1.
- Minimum spacing between accepted commands: k+2 cycles.
- abort sampled high in cycle j: done during cycle j+1; no toggle at the edge ending cycle j.
- All outputs are registered except t, cmd_ready and q_bar.
  - t and cmd_ready are decoded from state plus abort.
  - q_bar is the inverse of the q register.

## Test plan
- **Reset:** assert rst mid-cycle -> immediately q=0000, q_bar=1111, busy=0, done=0, t=0000. Deassert -> cmd_ready=1.
- **Single toggle:** mask=0101, N=1, G=0 accepted at E0 -> t=0101 in cycle 1; q=0101 after E1; done=1 in cycle 2; cmd_ready=1 in cycle 3.
- **Paced toggles:** mask=1111, N=3, G=2 from q=0000 -> q flips at E1, E4, E7 (1111, 0000, 1111); toggles_left steps 3→2→1→0; done in cycle 8.
- **Degenerate command:** N=0, mask=1111 -> no toggles, q unchanged, done in cycle 1. Repeat with N=5, mask=0000 -> same behaviour.
- **Abort in GAP:** mask=0011, N=4, G=3; abort during the first GAP cycle -> q stays 0011; done next cycle; toggles_left=0; no further t activity.
- **Backpressure and reset mid-command:**
  - cmd_valid held high with a new command while busy -> cmd_ready=0; the command is accepted on the first IDLE cycle after done.
  - rst asserted during TOGGLE -> all outputs return to reset values immediately.
